// File: rtl/upload_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// upload_arbiter_pkg
//   Shared definitions for the upload arbiter slice: source-ID constants used by
//   the handler upload ports, the default payload width and the arbiter FSM
//   state encoding.
//   No ports (package).
// -----------------------------------------------------------------------------
package upload_arbiter_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    // Source IDs carried alongside every uploaded byte.
    localparam logic [7:0] SRC_UART = 8'h01;
    localparam logic [7:0] SRC_I2C  = 8'h02;
    localparam logic [7:0] SRC_SPI  = 8'h03;
    localparam logic [7:0] SRC_CAN  = 8'h04;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/upload_arbiter_fifo.sv
// -----------------------------------------------------------------------------
// upload_arbiter_fifo
//   Synchronous FIFO holding {source,data} words for the upload arbiter. The
//   head word is read straight out of registered storage, so a word pushed on
//   one edge is visible (valid=1) right after that edge.
// Ports
//   clk, rst_n  clock, asynchronous active-low reset (flushes the FIFO)
//   push        write wdata this cycle
//   wdata       word to write
//   pop         remove the head word this cycle (ignored when empty)
//   rdata       head word, zero when empty
//   valid       FIFO is non-empty
//   full        level == DEPTH, from the registered level
//   level       current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module upload_arbiter_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign valid   = (level != '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop & valid;
    // A push into a full FIFO is safe only when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign rdata   = valid ? mem[rd_ptr] : '0;

    // NOTE: storage is deliberately not reset; pointers and level alone decide
    // which entries are live, and rdata is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/upload_arbiter.sv
// -----------------------------------------------------------------------------
// upload_arbiter
//   Merges NUM_SOURCES handler upload streams onto the single command_processor
//   upload interface. Round-robin arbitration with the grant locked for a whole
//   packet, a shared {source,data} FIFO and a stall watchdog that releases a
//   grant whose source holds req without sending bytes.
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   src_req        per-source packet request, held for the whole packet
//   src_data       packed bytes, source i at [i*DW +: DW]
//   src_source     packed source IDs, same packing
//   src_valid      per-source byte strobe
//   src_ready      byte accepted when src_valid & src_ready
//   upload_req     packet in flight (granted or FIFO non-empty)
//   upload_data    FIFO head byte
//   upload_source  FIFO head source ID
//   upload_valid   FIFO head valid
//   upload_ready   downstream pops the head when upload_valid & upload_ready
//   grant          one-hot active grant, zero when idle
//   timeout_pulse  one-cycle strobe on a watchdog release
//   fifo_level     current FIFO occupancy
// -----------------------------------------------------------------------------
module upload_arbiter
    import upload_arbiter_pkg::*;
#(
    parameter int NUM_SOURCES    = 4,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_SOURCES-1:0]            src_req,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0] src_data,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0] src_source,
    input  logic [NUM_SOURCES-1:0]            src_valid,
    output logic [NUM_SOURCES-1:0]            src_ready,
    output logic                              upload_req,
    output logic [DATA_WIDTH-1:0]             upload_data,
    output logic [DATA_WIDTH-1:0]             upload_source,
    output logic                              upload_valid,
    input  logic                              upload_ready,
    output logic [NUM_SOURCES-1:0]            grant,
    output logic                              timeout_pulse,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level
);

    localparam int IW = $clog2(NUM_SOURCES);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t                  state;
    state_t                  state_next;
    logic [IW-1:0]           gidx;
    logic [IW-1:0]           rr_ptr;
    logic [IW-1:0]           pick_idx;
    logic [IW-1:0]           cand;
    logic                    pick_found;
    logic [TW-1:0]           wd_cnt;
    logic                    g_req;
    logic                    g_valid;
    logic                    fifo_full;
    logic                    push;
    logic                    wd_idle;
    logic                    wd_fire;
    logic [2*DATA_WIDTH-1:0] push_word;
    logic [2*DATA_WIDTH-1:0] head_word;

    assign g_req     = src_req[gidx];
    assign g_valid   = src_valid[gidx];
    // A byte offered in the cycle req falls is still taken.
    assign push      = (state == ST_ACTIVE) & g_valid & ~fifo_full;
    assign wd_idle   = (state == ST_ACTIVE) & g_req & ~g_valid;
    assign wd_fire   = (TIMEOUT_CYCLES != 0) & wd_idle &
                       (wd_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign push_word = {src_source[gidx*DATA_WIDTH +: DATA_WIDTH],
                        src_data[gidx*DATA_WIDTH +: DATA_WIDTH]};

    assign upload_source = head_word[2*DATA_WIDTH-1:DATA_WIDTH];
    assign upload_data   = head_word[DATA_WIDTH-1:0];

    // Round-robin pick: first requester strictly after rr_ptr, wrapping.
    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_ptr;
        cand       = rr_ptr;
        for (int k = 1; k <= NUM_SOURCES; k++) begin
            cand = IW'((int'(rr_ptr) + k) % NUM_SOURCES);
            if (!pick_found && src_req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (pick_found)         state_next = ST_ACTIVE;
            ST_ACTIVE: if (!g_req || wd_fire)  state_next = ST_IDLE;
            default:                           state_next = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        src_ready  = '0;
        upload_req = (fifo_level != '0);
        if (state == ST_ACTIVE) begin
            src_ready[gidx] = ~fifo_full;
            upload_req      = 1'b1;
        end
    end

    // Grant, round-robin pointer and watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant         <= '0;
            gidx          <= '0;
            rr_ptr        <= IW'(NUM_SOURCES - 1);
            wd_cnt        <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= wd_fire;
            case (state)
                ST_IDLE: begin
                    wd_cnt <= '0;
                    if (pick_found) begin
                        gidx  <= pick_idx;
                        grant <= NUM_SOURCES'(1) << pick_idx;
                    end
                end
                ST_ACTIVE: begin
                    if (!g_req || wd_fire) begin
                        rr_ptr <= gidx;
                        grant  <= '0;
                        wd_cnt <= '0;
                    end else if (push) begin
                        wd_cnt <= '0;
                    end else if (wd_idle) begin
                        wd_cnt <= wd_cnt + TW'(1);
                    end
                end
                default: grant <= '0;
            endcase
        end
    end

    upload_arbiter_fifo #(
        .WIDTH (2*DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_word),
        .pop   (upload_ready),
        .rdata (head_word),
        .valid (upload_valid),
        .full  (fifo_full),
        .level (fifo_level)
    );

endmodule

// File: tb/tb_upload_arbiter.sv
// -----------------------------------------------------------------------------
// tb_upload_arbiter
//   Self-checking bench for upload_arbiter (4 sources, 8-bit, 16-deep FIFO,
//   watchdog of 8 cycles). Accepted source bytes are queued as expectations and
//   compared against every downstream pop.
// -----------------------------------------------------------------------------
module tb_upload_arbiter;
    import upload_arbiter_pkg::*;

    localparam int NS    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int TO    = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NS-1:0]     src_req;
    logic [NS*DW-1:0]  src_data;
    logic [NS*DW-1:0]  src_source;
    logic [NS-1:0]     src_valid;
    logic [NS-1:0]     src_ready;
    logic              upload_req;
    logic [DW-1:0]     upload_data;
    logic [DW-1:0]     upload_source;
    logic              upload_valid;
    logic              upload_ready;
    logic [NS-1:0]     grant;
    logic              timeout_pulse;
    logic [LW-1:0]     fifo_level;

    int n_cmp = 0;
    int n_err = 0;
    int n_rx  = 0;
    logic [2*DW-1:0] sb_q[$];

    typedef struct packed {
        logic [NS-1:0] req;
        logic [NS-1:0] exp_grant;
    } vec_t;
    vec_t vecs[10];

    always #5 clk = ~clk;

    upload_arbiter #(
        .NUM_SOURCES    (NS),
        .DATA_WIDTH     (DW),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .src_req       (src_req),
        .src_data      (src_data),
        .src_source    (src_source),
        .src_valid     (src_valid),
        .src_ready     (src_ready),
        .upload_req    (upload_req),
        .upload_data   (upload_data),
        .upload_source (upload_source),
        .upload_valid  (upload_valid),
        .upload_ready  (upload_ready),
        .grant         (grant),
        .timeout_pulse (timeout_pulse),
        .fifo_level    (fifo_level)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: downstream pops are compared first, then bytes accepted from
    // the sources this cycle are queued.
    always @(negedge clk) begin
        if (rst_n) begin
            if (upload_valid && upload_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL upload_unexpected: got 0x%0h, nothing expected",
                             {upload_source, upload_data});
                end else begin
                    check("upload_byte", {upload_source, upload_data}, sb_q.pop_front());
                end
                n_rx++;
            end
            for (int i = 0; i < NS; i++) begin
                if (src_valid[i] && src_ready[i]) begin
                    sb_q.push_back({src_source[i*DW +: DW], src_data[i*DW +: DW]});
                end
            end
            if (fifo_level > LW'(DEPTH)) begin
                n_err++;
                $display("FAIL fifo_overflow: got level %0d, limit %0d", fifo_level, DEPTH);
            end
        end
    end

    task automatic send(input int s, input int n, input logic [7:0] base,
                        input logic [7:0] id, input bit drop_last, input bit keep_req);
        bit acc;
        int budget;
        src_req[s] = 1'b1;
        src_source[s*DW +: DW] = id;
        for (int k = 0; k < n; k++) begin
            src_valid[s] = 1'b1;
            src_data[s*DW +: DW] = base + 8'(k);
            if (drop_last && k == n - 1) src_req[s] = 1'b0;
            acc = 1'b0;
            budget = 200;
            while (!acc && budget > 0) begin
                @(negedge clk);
                acc = src_ready[s];
                tick();
                budget--;
            end
            if (!acc) begin
                n_cmp++;
                n_err++;
                $display("FAIL send_timeout: got no ready for src%0d byte %0d, expected ready", s, k);
                break;
            end
        end
        src_valid[s] = 1'b0;
        if (!keep_req) src_req[s] = 1'b0;
    endtask

    task automatic wait_drain();
        int budget = 100;
        while ((fifo_level != '0 || upload_valid) && budget > 0) begin
            tick();
            budget--;
        end
        check("drain_level", fifo_level, 0);
    endtask

    task automatic check_all_zero(input string p);
        check({p, "_grant"},      grant, 0);
        check({p, "_src_ready"},  src_ready, 0);
        check({p, "_upload_req"}, upload_req, 0);
        check({p, "_valid"},      upload_valid, 0);
        check({p, "_head"},       {upload_source, upload_data}, 0);
        check({p, "_timeout"},    timeout_pulse, 0);
        check({p, "_level"},      fifo_level, 0);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        src_req    = '0;
        src_valid  = '0;
        src_data   = '0;
        src_source = '0;
        sb_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int rx0;
        int held;
        int pulses;

        // Round-robin vectors, starting from the reset pointer (source 3).
        vecs[0] = '{req: 4'b0101, exp_grant: 4'b0001};
        vecs[1] = '{req: 4'b0101, exp_grant: 4'b0100};
        vecs[2] = '{req: 4'b0101, exp_grant: 4'b0001};
        vecs[3] = '{req: 4'b1010, exp_grant: 4'b0010};
        vecs[4] = '{req: 4'b1010, exp_grant: 4'b1000};
        vecs[5] = '{req: 4'b1111, exp_grant: 4'b0001};
        vecs[6] = '{req: 4'b1110, exp_grant: 4'b0010};
        vecs[7] = '{req: 4'b0010, exp_grant: 4'b0010};
        vecs[8] = '{req: 4'b1001, exp_grant: 4'b1000};
        vecs[9] = '{req: 4'b0110, exp_grant: 4'b0010};

        rst_n        = 1'b0;
        src_req      = '0;
        src_valid    = '0;
        src_data     = '0;
        src_source   = '0;
        upload_ready = 1'b0;
        repeat (2) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        upload_ready = 1'b1;

        // Single source packet.
        rx0 = n_rx;
        src_req[1] = 1'b1;
        tick();
        check("t1_grant", grant, 4'b0010);
        check("t1_src_ready", src_ready, 4'b0010);
        check("t1_upload_req", upload_req, 1);
        send(1, 3, 8'hA1, SRC_I2C, 1'b0, 1'b0);
        wait_drain();
        tick();
        check("t1_upload_req_fall", upload_req, 0);
        check("t1_rx_count", n_rx - rx0, 3);

        // Round-robin table.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            src_req = vecs[i].req;
            tick();
            check($sformatf("rr_grant_%0d", i), grant, vecs[i].exp_grant);
            src_req = '0;
            tick();
            check($sformatf("rr_release_%0d", i), grant, 0);
        end

        // Grant lock under contention, pointer now at source 1.
        src_req = 4'b0101;
        tick();
        check("lock_first", grant, 4'b0100);
        repeat (3) tick();
        check("lock_held", grant, 4'b0100);
        src_req[2] = 1'b0;
        tick();
        check("lock_release", grant, 0);
        tick();
        check("lock_next", grant, 4'b0001);
        src_req = '0;
        repeat (2) tick();

        // Backpressure, then push+pop around full.
        upload_ready = 1'b0;
        rx0 = n_rx;
        fork
            send(3, 20, 8'h10, SRC_CAN, 1'b0, 1'b0);
            begin
                int budget = 100;
                while (fifo_level != LW'(DEPTH) && budget > 0) begin
                    tick();
                    budget--;
                end
                check("bp_level_full", fifo_level, DEPTH);
                check("bp_ready_low", src_ready[3], 0);
                tick();
                check("bp_level_hold", fifo_level, DEPTH);
                upload_ready = 1'b1;
                tick();
                check("full_pop_no_push", fifo_level, DEPTH - 1);
                tick();
                check("push_pop_level", fifo_level, DEPTH - 1);
            end
        join
        wait_drain();
        check("bp_rx_count", n_rx - rx0, 20);
        check("bp_sb_empty", sb_q.size(), 0);

        // Watchdog release.
        do_reset();
        upload_ready = 1'b1;
        src_req[2] = 1'b1;
        send(1, 1, 8'h55, SRC_I2C, 1'b0, 1'b1);
        held = 0;
        pulses = 0;
        for (int c = 1; c < TO; c++) begin
            tick();
            if (grant == 4'b0010) held++;
            if (timeout_pulse) pulses++;
        end
        check("wd_grant_held", held, TO - 1);
        check("wd_no_early_pulse", pulses, 0);
        tick();
        check("wd_grant_cleared", grant, 0);
        check("wd_pulse", timeout_pulse, 1);
        tick();
        check("wd_pulse_one_cycle", timeout_pulse, 0);
        check("wd_next_grant", grant, 4'b0100);
        src_req = '0;
        repeat (2) tick();
        wait_drain();

        // Last byte offered in the cycle req falls.
        rx0 = n_rx;
        send(0, 2, 8'hC0, SRC_UART, 1'b1, 1'b0);
        wait_drain();
        check("req_fall_rx_count", n_rx - rx0, 2);
        check("req_fall_idle", grant, 0);

        // Reset in the middle of a packet.
        upload_ready = 1'b0;
        src_req[2] = 1'b1;
        src_source[2*DW +: DW] = SRC_SPI;
        src_data[2*DW +: DW] = 8'h77;
        src_valid[2] = 1'b1;
        repeat (4) tick();
        check("mid_pkt_level", fifo_level, 3);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        sb_q.delete();
        src_req = '0;
        src_valid = '0;
        tick();
        rst_n = 1'b1;
        upload_ready = 1'b1;
        tick();
        check("post_rst_grant", grant, 0);
        rx0 = n_rx;
        send(2, 2, 8'h88, SRC_SPI, 1'b0, 1'b0);
        wait_drain();
        check("post_rst_rx_count", n_rx - rx0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
